// File: rtl/button_out_port.sv
// button_out_port: memory-mapped board output line with level and timed-pulse modes plus a status word
module button_out_port #(
    parameter logic [31:0] OUT_ADDR  = 32'd1001,
    parameter logic [31:0] STAT_ADDR = 32'd1002
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic        button_out,
    output logic [31:0] q_status,
    output logic        status_sel
);
    typedef enum logic {IDLE, PULSE} state_t;
    state_t      state_q, state_d;
    logic [23:0] rem_q, rem_d;
    logic        lvl_q, lvl_d;
    logic        button_out_q, button_out_d;
    logic        accept;
    assign accept = wren && (address_dmem == OUT_ADDR);
    // Next state: an accepted write always wins over the running pulse countdown
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        lvl_d        = lvl_q;
        if (accept) begin
            lvl_d   = data[31] ? 1'b0 : data[0];
            rem_d   = data[31] ? data[23:0] : 24'd0;
            state_d = (data[31] && data[23:0] != 24'd0) ? PULSE : IDLE;
        end else if (state_q == PULSE) begin
            rem_d   = rem_q - 24'd1;
            state_d = (rem_q == 24'd1) ? IDLE : PULSE;
        end
        button_out_d = (state_d == PULSE) ? 1'b1 : lvl_d;
    end
    // State registers; reset overrides any write on the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rem_q        <= 24'd0;
            lvl_q        <= 1'b0;
            button_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            lvl_q        <= lvl_d;
            button_out_q <= button_out_d;
        end
    end
    assign button_out = button_out_q;
    assign q_status   = {state_q == PULSE, 6'b0, lvl_q, rem_q};
    assign status_sel = (address_dmem == STAT_ADDR);
endmodule

// File: tb/tb_button_out_port.sv
// tb_button_out_port: directed stimulus checked against a cycle-count model of the output port
module tb_button_out_port;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren = 1'b0;
    logic [31:0] address_dmem = 32'd0;
    logic [31:0] data = 32'd0;
    logic        button_out;
    logic [31:0] q_status;
    logic        status_sel;
    int checks = 0;
    int errors = 0;
    int m_left = 0;
    logic m_lvl = 1'b0;
    int high;

    button_out_port dut (
        .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
        .data(data), .button_out(button_out), .q_status(q_status), .status_sel(status_sel)
    );

    always #5 clock = ~clock;

    // Model: m_left is how many more cycles the pulse keeps the line high
    always @(posedge clock) begin
        if (reset) begin
            m_left = 0;
            m_lvl  = 1'b0;
        end else if (wren && address_dmem == 32'd1001) begin
            m_lvl  = data[31] ? 1'b0 : data[0];
            m_left = data[31] ? int'(data[23:0]) : 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare();
        logic [31:0] eq;
        eq = {m_left > 0, 6'b0, m_lvl, 24'(m_left)};
        lit("model_button_out", {31'b0, button_out}, {31'b0, (m_left > 0) || m_lvl});
        lit("model_q_status", q_status, eq);
        lit("model_status_sel", {31'b0, status_sel}, {31'b0, address_dmem == 32'd1002});
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        reset = r;
        wren = w;
        address_dmem = a;
        data = d;
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 32'd1001, 32'h0000_0001);
        lit("reset_out", {31'b0, button_out}, 32'd0);
        lit("reset_status", q_status, 32'd0);
        // level write
        step(1'b0, 1'b1, 32'd1001, 32'h0000_0001);
        lit("level_out", {31'b0, button_out}, 32'd1);
        lit("level_status", q_status, 32'h0100_0000);
        idle();
        // pulse of 5
        step(1'b0, 1'b1, 32'd1001, 32'h8000_0005);
        lit("pulse5_first", q_status, 32'h8000_0005);
        high = button_out ? 1 : 0;
        for (int i = 1; i <= 6; i++) begin
            idle();
            lit("pulse5_status", q_status, (i < 5) ? 32'h8000_0000 | 32'(5 - i) : 32'd0);
            if (button_out) high++;
        end
        lit("pulse5_high", 32'(high), 32'd5);
        // pulse of 10 restarted to 3 after 4 cycles
        step(1'b0, 1'b1, 32'd1001, 32'h8000_000A);
        high = button_out ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            idle();
            if (button_out) high++;
        end
        step(1'b0, 1'b1, 32'd1001, 32'h8000_0003);
        lit("restart_status", q_status, 32'h8000_0003);
        if (button_out) high++;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (button_out) high++;
        end
        lit("restart_high", 32'(high), 32'd7);
        // level write on the final-decrement edge
        step(1'b0, 1'b1, 32'd1001, 32'h8000_0002);
        idle();
        lit("final_rem1", q_status, 32'h8000_0001);
        step(1'b0, 1'b1, 32'd1001, 32'h0000_0001);
        lit("final_out", {31'b0, button_out}, 32'd1);
        lit("final_status", q_status, 32'h0100_0000);
        // ignored writes
        step(1'b0, 1'b1, 32'd1000, 32'h8000_0007);
        lit("ign1000", q_status, 32'h0100_0000);
        step(1'b0, 1'b1, 32'd1002, 32'h8000_0007);
        lit("ign1002", q_status, 32'h0100_0000);
        lit("sel_1002", {31'b0, status_sel}, 32'd1);
        step(1'b0, 1'b0, 32'd1002, 32'h0000_0000);
        lit("sel_nowren", {31'b0, status_sel}, 32'd1);
        step(1'b0, 1'b0, 32'd1001, 32'h0000_0000);
        lit("ign_nowren", q_status, 32'h0100_0000);
        lit("sel_1001", {31'b0, status_sel}, 32'd0);
        lit("ign_out", {31'b0, button_out}, 32'd1);
        // reset mid-pulse, then zero-length pulse
        step(1'b0, 1'b1, 32'd1001, 32'h8000_0008);
        idle();
        idle();
        step(1'b1, 1'b1, 32'd1001, 32'h0000_0001);
        lit("midreset_out", {31'b0, button_out}, 32'd0);
        lit("midreset_status", q_status, 32'd0);
        step(1'b0, 1'b1, 32'd1001, 32'h8000_0000);
        lit("zero_pulse_out", {31'b0, button_out}, 32'd0);
        lit("zero_pulse_status", q_status, 32'd0);
        for (int i = 0; i < 3; i++) idle();
        lit("no_residual", q_status, 32'd0);
        // fresh pulse after reset
        step(1'b0, 1'b1, 32'd1001, 32'h8000_0002);
        high = button_out ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (button_out) high++;
        end
        lit("post_reset_high", 32'(high), 32'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
